// File: rtl/ysyx_22040088_pkg.sv
// Shared definitions for the instruction fetch unit and the control unit that
// drives its next-PC selection.
package ysyx_22040088_pkg;

  // Bit positions inside the one-hot sel_nextpc vector.
  localparam int SEL_SEQ  = 0;
  localparam int SEL_JAL  = 1;
  localparam int SEL_JALR = 2;
  localparam int SEL_BEQ  = 3;
  localparam int SEL_BNE  = 4;
  localparam int SEL_BLT  = 5;
  localparam int SEL_BGE  = 6;
  localparam int SEL_W    = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } ifu_state_t;

  localparam logic [1:0] HALT_NONE     = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL  = 2'd1;
  localparam logic [1:0] HALT_MISALIGN = 2'd2;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // True when exactly one bit of the selection vector is set.
  function automatic logic is_onehot(input logic [SEL_W-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ysyx_22040088_nextpc.sv
// Combinational next-PC selection: decodes the one-hot control vector and
// flags illegal selections and misaligned targets.
module ysyx_22040088_nextpc
  import ysyx_22040088_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]  pc,
  input  logic [SEL_W-1:0] sel_nextpc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic             alu_zero,
  input  logic             alu_lt,
  output logic [XLEN-1:0]  next_pc,
  output logic             illegal,
  output logic             misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] jalr_pc;

  assign seq_pc  = pc + XLEN'(4);
  assign br_pc   = pc + imm;
  assign jalr_pc = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};

  always_comb begin
    next_pc = seq_pc;
    if (sel_nextpc[SEL_JAL])       next_pc = br_pc;
    else if (sel_nextpc[SEL_JALR]) next_pc = jalr_pc;
    else if (sel_nextpc[SEL_BEQ])  next_pc = alu_zero  ? br_pc : seq_pc;
    else if (sel_nextpc[SEL_BNE])  next_pc = !alu_zero ? br_pc : seq_pc;
    else if (sel_nextpc[SEL_BLT])  next_pc = alu_lt    ? br_pc : seq_pc;
    else if (sel_nextpc[SEL_BGE])  next_pc = !alu_lt   ? br_pc : seq_pc;
  end

  assign illegal    = !is_onehot(sel_nextpc);
  // jalr only clears bit 0, so bit 1 can still leave the target misaligned.
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per loop and
// applies the control unit's next-PC selection on commit.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready and, once raised,
// holds with stable payload until that transfer.
module ysyx_22040088_ifu
  import ysyx_22040088_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  pc,
  input  logic [SEL_W-1:0] sel_nextpc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic             alu_zero,
  input  logic             alu_lt,
  output logic             halt,
  output logic [1:0]       halt_cause
);

  ifu_state_t      state;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [1:0]      cause_q;
  logic [XLEN-1:0] next_pc;
  logic            illegal;
  logic            misaligned;

  ysyx_22040088_nextpc #(.XLEN(XLEN)) u_nextpc (
    .pc         (pc_q),
    .sel_nextpc (sel_nextpc),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .next_pc    (next_pc),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cause_q <= HALT_NONE;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        // Responses are only honoured here, so a stale one after reset is dropped.
        S_WAIT: begin
          if (imem_resp_valid) begin
            inst_q <= imem_resp_data;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            if (illegal) begin
              cause_q <= HALT_ILLEGAL;
              state   <= S_HALT;
            end else if (misaligned) begin
              cause_q <= HALT_MISALIGN;
              state   <= S_HALT;
            end else begin
              pc_q  <= next_pc;
              state <= S_REQ;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = (state == S_HOLD);
  assign pc             = pc_q;
  assign halt           = (state == S_HALT);
  assign halt_cause     = cause_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Directed self-checking bench for the instruction fetch unit.
module tb_ysyx_22040088_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] pc;
  logic [6:0]  sel_nextpc = '0;
  logic [63:0] imm = '0;
  logic [63:0] rs1_val = '0;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic        halt;
  logic [1:0]  halt_cause;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;

  ysyx_22040088_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .pc              (pc),
    .sel_nextpc      (sel_nextpc),
    .imm             (imm),
    .rs1_val         (rs1_val),
    .alu_zero        (alu_zero),
    .alu_lt          (alu_lt),
    .halt            (halt),
    .halt_cause      (halt_cause)
  );

  // Clock and cycle counter; stimulus and sampling happen on the falling edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_req: imem_req_valid=%b after %0d cycles, required 1", imem_req_valid, n);
    end
    req_cyc = cyc;
  endtask

  // Memory side: hold ready low for stall cycles, then answer delay cycles
  // after acceptance.
  task automatic serve(input logic [63:0] exp_addr, input logic [31:0] data,
                       input int stall, input int delay);
    wait_req();
    checks++;
    if (imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL serve_addr: imem_addr=%h required %h", imem_addr, exp_addr);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL stall_hold: valid=%b addr=%h required 1 %h", imem_req_valid, imem_addr, exp_addr);
      end
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_inst_valid: inst_valid=%b required 0", inst_valid);
      end
      @(negedge clk);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data = data;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== data) begin
      errors++;
      $display("FAIL capture: inst_valid=%b inst=%h required 1 %h", inst_valid, inst, data);
    end
  endtask

  task automatic commit(input logic [6:0] sel, input logic [63:0] im, input logic [63:0] rs1,
                        input logic z, input logic lt, input logic [63:0] exp_pc);
    sel_nextpc = sel;
    imm = im;
    rs1_val = rs1;
    alu_zero = z;
    alu_lt = lt;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    sel_nextpc = 7'h7f;
    imm = '1;
    rs1_val = '1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL commit_drop: inst_valid=%b required 0", inst_valid);
    end
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL commit_pc: pc=%h required %h", pc, exp_pc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halt !== 1'b0 || halt_cause !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b iv=%b halt=%b cause=%0d required 0 0 0 0",
               imem_req_valid, inst_valid, halt, halt_cause);
    end
    checks++;
    if (pc !== RST_PC || imem_addr !== RST_PC || inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: pc=%h addr=%h inst=%h required %h %h 0", pc, imem_addr, inst, RST_PC, RST_PC);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_req: imem_req_valid=%b required 1 in 2nd cycle", imem_req_valid);
    end
  endtask

  task automatic test_sequential();
    int prev;
    serve(64'h8000_0000, 32'h0000_0013, 0, 0);
    commit(7'b0000001, 64'h0, 64'h0, 1'b0, 1'b0, 64'h8000_0004);
    prev = req_cyc;
    serve(64'h8000_0004, 32'h0010_0093, 0, 0);
    checks++;
    if (req_cyc - prev !== 3) begin
      errors++;
      $display("FAIL loop_cycles: %0d cycles per instruction, required 3", req_cyc - prev);
    end
    commit(7'b0000001, 64'h0, 64'h0, 1'b0, 1'b0, 64'h8000_0008);
    serve(64'h8000_0008, 32'h0020_0113, 0, 0);
    commit(7'b0000001, 64'h0, 64'h0, 1'b0, 1'b0, 64'h8000_000C);
    serve(64'h8000_000C, 32'h0030_0193, 0, 0);
    commit(7'b0000001, 64'h0, 64'h0, 1'b0, 1'b0, 64'h8000_0010);
  endtask

  task automatic test_branch();
    serve(64'h8000_0010, 32'h0200_0063, 0, 0);
    commit(7'b0001000, 64'h20, 64'h0, 1'b1, 1'b0, 64'h8000_0030);
    serve(64'h8000_0030, 32'hFE1F_F06F, 0, 0);
    commit(7'b0000010, 64'hFFFF_FFFF_FFFF_FFE0, 64'h0, 1'b0, 1'b0, 64'h8000_0010);
    serve(64'h8000_0010, 32'h0200_0063, 0, 0);
    commit(7'b0001000, 64'h20, 64'h0, 1'b0, 1'b0, 64'h8000_0014);
    serve(64'h8000_0014, 32'h0000_5463, 0, 0);
    commit(7'b1000000, 64'h8, 64'h0, 1'b0, 1'b0, 64'h8000_001C);
    serve(64'h8000_001C, 32'h0000_4263, 0, 0);
    commit(7'b0100000, 64'h40, 64'h0, 1'b0, 1'b0, 64'h8000_0020);
    serve(64'h8000_0020, 32'h0000_1463, 0, 0);
    commit(7'b0010000, 64'h8, 64'h0, 1'b1, 1'b0, 64'h8000_0024);
  endtask

  task automatic test_jalr();
    serve(64'h8000_0024, 32'h0030_8067, 0, 0);
    commit(7'b0000100, 64'h3, 64'h8000_0101, 1'b0, 1'b0, 64'h8000_0104);
  endtask

  task automatic test_stall();
    serve(64'h8000_0104, 32'hDEAD_BEEF, 4, 5);
    commit(7'b0000001, 64'h0, 64'h0, 1'b0, 1'b0, 64'h8000_0108);
  endtask

  task automatic test_illegal();
    logic seen = 1'b0;
    serve(64'h8000_0108, 32'h0000_0000, 0, 0);
    commit(7'b0000000, 64'h0, 64'h0, 1'b0, 1'b0, 64'h8000_0108);
    checks++;
    if (halt !== 1'b1 || halt_cause !== 2'd1) begin
      errors++;
      $display("FAIL illegal_halt: halt=%b cause=%0d required 1 1", halt, halt_cause);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | imem_req_valid;
    end
    checks++;
    if (seen !== 1'b0 || halt !== 1'b1 || pc !== 64'h8000_0108) begin
      errors++;
      $display("FAIL halt_sticky: req_seen=%b halt=%b pc=%h required 0 1 80000108", seen, halt, pc);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    serve(RST_PC, 32'h0020_006F, 0, 0);
    commit(7'b0000010, 64'h2, 64'h0, 1'b0, 1'b0, RST_PC);
    checks++;
    if (halt !== 1'b1 || halt_cause !== 2'd2) begin
      errors++;
      $display("FAIL misaligned_halt: halt=%b cause=%0d required 1 2", halt, halt_cause);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    serve(RST_PC, 32'h1111_1111, 0, 0);
    commit(7'b0000001, 64'h0, 64'h0, 1'b0, 1'b0, 64'h8000_0004);
    wait_req();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || pc !== RST_PC || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait: req=%b pc=%h iv=%b required 1 %h 0", imem_req_valid, pc, inst_valid, RST_PC);
    end
    @(negedge clk);
    imem_resp_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL stale_resp: iv=%b req=%b required 0 1", inst_valid, imem_req_valid);
    end
    serve(RST_PC, 32'h0010_0073, 0, 2);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall();
    test_illegal();
    test_misaligned();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_ifu.md
# ysyx_22040088_ifu

Instruction fetch unit for the single-issue NPC core. It owns the architectural PC and fetches one 32-bit instruction per loop over a valid/ready instruction-memory port. It presents the instruction to the decode/execute stage and then applies the one-hot `sel_nextpc` vector coming back from the control unit to pick the next PC. It is the producer of the instruction and the consumer of the control unit's next-PC selection, which is the other end of that interface.

## Interface
- `RESET_PC`, 64'h8000_0000, PC value after reset.
- `XLEN`, 64, data/address width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  XLEN  fetch address; always equals `pc`.
- `imem_resp_valid`  in  1  response data valid.
- `imem_resp_data`  in  32  fetched instruction.
- `inst`  out  32  instruction held for decode.
- `inst_valid`  out  1  `inst` is valid and awaiting commit.
- `inst_ready`  in  1  execute stage commits the current instruction.
- `pc`  out  XLEN  PC of the current instruction.
- `sel_nextpc`  in  7  one-hot, from the control unit: [6] bge/bgeu, [5] blt/bltu, [4] bne, [3] beq, [2] jalr, [1] jal, [0] sequential.
- `imm`  in  XLEN  sign-extended immediate of the current instruction.
- `rs1_val`  in  XLEN  rs1 operand, used for the jalr target.
- `alu_zero`  in  1  ALU result == 0 (sub compare).
- `alu_lt`  in  1  bit 0 of the slt/sltu result.
- `halt`  out  1  sticky; fetch has stopped.
- `halt_cause`  out  2  0 none, 1 illegal `sel_nextpc`, 2 misaligned target.

## Operation
- States:
  - IDLE: no request.
  - REQ: `imem_req_valid`=1.
  - WAIT: waiting for the response.
  - HOLD: `inst_valid`=1.
  - HALT: terminal.
- Transitions:
  - IDLE→REQ unconditionally.
  - REQ→WAIT on `imem_req_valid && imem_req_ready`.
  - WAIT→HOLD on `imem_resp_valid`; `inst` is captured on that edge.
  - HOLD→REQ on `inst_ready`, when the next-PC computation is legal; `pc` updates on that edge.
  - HOLD→HALT on `inst_ready`, when the selection is illegal or the target is misaligned.
  - HALT is left only by `rst`.
- Next PC:
  - seq: `pc+4`.
  - jal: `pc+imm`.
  - jalr: `(rs1_val+imm) & ~1`.
  - beq: taken if `alu_zero`.
  - bne: taken if `!alu_zero`.
  - blt/bltu: taken if `alu_lt`.
  - bge/bgeu: taken if `!alu_lt`.
  - A taken branch goes to `pc+imm`; a not-taken branch goes to `pc+4`.
- All additions are modulo 2^XLEN; wrap-around is silent.
- Illegal selection: `sel_nextpc` is zero or has more than one bit set. The block sets `halt`, sets `halt_cause`=1, and leaves `pc` unchanged.
- Misaligned target: next PC bits [1:0] != 0. The block sets `halt`, sets `halt_cause`=2, and leaves `pc` unchanged.
- `sel_nextpc`, `imm`, `rs1_val`, `alu_zero` and `alu_lt` are sampled only in HOLD on the commit edge. They are ignored at all other times.
- `imem_resp_valid` is sampled only in WAIT. A response arriving in REQ is a protocol error and is ignored.

## Timing
- Values after a reset edge:
  - state IDLE
  - `pc`=RESET_PC
  - `inst`=0
  - `inst_valid`=0
  - `imem_req_valid`=0
  - `halt`=0
  - `halt_cause`=0
- The first request is asserted in the 2nd cycle after the reset edge.
- Minimum loop is 3 cycles per instruction: REQ (ready=1), WAIT (resp=1 the following cycle), HOLD (ready=1).
- `imem_req_valid` stays high in REQ until accepted. `imem_addr` is stable while `imem_req_valid` is high.
- `inst` and `pc` are stable for the whole time `inst_valid` is high.
- `inst_valid` drops on the cycle after commit.
- Reset mid-operation (any state, including HALT) returns to IDLE on the next edge.
  - An outstanding memory response is discarded: WAIT is not re-entered until a new request is accepted.
- All outputs are decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Package `ysyx_22040088_pkg` holds:
  - `sel_nextpc` bit-index constants (shared with the control unit)
  - IFU state enum
  - halt-cause codes
  - default RESET_PC
- Sub-module `ysyx_22040088_nextpc`: purely combinational. It takes `pc`, `sel_nextpc`, `imm`, `rs1_val`, `alu_zero` and `alu_lt`, and produces `next_pc`, `illegal` and `misaligned`.
- The IFU instantiates `ysyx_22040088_nextpc` plus the FSM and the PC/inst registers.

## Test plan
- Reset, then 3 commits with `sel_nextpc`=7'b0000001, zero-wait memory → `imem_addr` 0x8000_0000, 0x8000_0004, 0x8000_0008. First request in the 2nd cycle after reset; 3 cycles per instruction.
- beq at 0x8000_0010 with imm=0x20:
  - `alu_zero`=1 → next `pc`=0x8000_0030.
  - Repeat with `alu_zero`=0 → next `pc`=0x8000_0014.
- jalr with rs1_val=0x8000_0101, imm=3 → next `pc`=0x8000_0104.
- Memory stalls: `imem_req_ready` low 4 cycles, then response 5 cycles later → `imem_req_valid` and `imem_addr` held constant, `inst_valid` stays 0 until the capture, `inst` equals the response data.
- Error cases:
  - `sel_nextpc`=7'b0000000 at commit → `halt`=1, `halt_cause`=1, no further requests, `pc` unchanged.
  - jal with imm=2 → `halt_cause`=2.
- Assert `rst` in WAIT, then drive a late `imem_resp_valid` → the response is ignored, IDLE→REQ at RESET_PC, and the first captured `inst` is from the new request.
